hazard_ctrl: RTL

- Hazard and pipeline-sequencing controller for the 5-stage core (F/D/E/M/W).
- Drives the hold (en) and clear (clr) inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Generates forwarding selects for the D and E stages.
- Sequences the multi-cycle mult/div unit with an internal busy counter FSM, so dependent instructions stall until HI/LO are valid.

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection, forwarding selects and mult/div busy
// sequencing for the 5-stage F/D/E/M/W core.
// Optional feature macro: HAZARD_PERF_EN adds StallCnt/FlushCnt
// performance counters (cycles stalled, cycles with a taken-branch flush).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | MDU free; a mult/div start in E loads the busy counter
// BUSY  | MDU computing; cnt counts down to 0, HI/LO valid after that
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] RegAddrE,
  input  logic [4:0] RegAddrM,
  input  logic [4:0] RegAddrW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       TakenD,
  input  logic       MdStartE,
  input  logic       MdDivE,
  input  logic       MdUseD,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
`ifdef HAZARD_PERF_EN
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt,
`endif
  output logic       MdBusy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Counter is loaded with N-1 so that BUSY lasts exactly N cycles.
  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  logic [0:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       lw_stall, br_stall, md_stall, stall;

  // Register 0 is hardwired, so a match on it never creates a hazard.
  function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  // E-stage operand select: M result has priority over W result.
  function automatic logic [1:0] fwd_e(input logic [4:0] src,
                                       input logic we_m, input logic [4:0] ad_m,
                                       input logic we_w, input logic [4:0] ad_w);
    if (we_m && hit(ad_m, src))      return 2'b10;
    else if (we_w && hit(ad_w, src)) return 2'b01;
    else                             return 2'b00;
  endfunction

  assign MdBusy = (state_q == S_BUSY);

  // Forwarding selects and stall/flush generation.
  always_comb begin
    ForwardAE = fwd_e(RsE, RegWriteM, RegAddrM, RegWriteW, RegAddrW);
    ForwardBE = fwd_e(RtE, RegWriteM, RegAddrM, RegWriteW, RegAddrW);
    // A load in M has no ALU result to forward to the branch comparator.
    ForwardAD = RegWriteM && hit(RegAddrM, RsD) && !MemtoRegM;
    ForwardBD = RegWriteM && hit(RegAddrM, RtD) && !MemtoRegM;

    lw_stall = MemtoRegE && (hit(RegAddrE, RsD) || hit(RegAddrE, RtD));
    br_stall = BranchD &&
               ((RegWriteE && (hit(RegAddrE, RsD) || hit(RegAddrE, RtD))) ||
                (MemtoRegM && (hit(RegAddrM, RsD) || hit(RegAddrM, RtD))));
    md_stall = MdUseD && (MdBusy || MdStartE);
    stall    = lw_stall | br_stall | md_stall;

    StallF = stall;
    StallD = stall;
    FlushE = stall;
    // A taken branch only squashes F once its own operands are resolved.
    FlushD = TakenD && !stall;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushM = 1'b0;
  end

  // MDU busy FSM next-state; starts while BUSY are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (MdStartE) begin
        state_d = S_BUSY;
        cnt_d   = MdDivE ? DIV_LOAD : MULT_LOAD;
      end
    end else begin
      if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      else               state_d = S_IDLE;
    end
  end

  // MDU busy FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Performance counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, stall};
      flush_cnt_q <= flush_cnt_q + {31'd0, FlushD};
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule
